// File: rtl/microop_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : microop_sequencer_pkg
// Description : Shared control-logic constants: in_plane load codes, reg_sel
//               codes, reserved opcodes, opword field positions and the
//               misc_plane counter-reset value. Imported by the microcode ROM
//               and the micro-op sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package microop_sequencer_pkg;

  // Field widths shared by the sequencer and the ROM interface
  localparam int IN_PLANE_W  = 3;
  localparam int REG_SEL_W   = 2;
  localparam int CTRL_DATA_W = 6;
  localparam int REG_IDX_W   = 5;
  localparam int IMM_W       = 16;

  // in_plane codes: what the sequencer loads from this micro-op
  localparam logic [IN_PLANE_W-1:0] IN_NONE   = 3'd0;
  localparam logic [IN_PLANE_W-1:0] IN_OPCODE = 3'd1;
  localparam logic [IN_PLANE_W-1:0] IN_OPWORD = 3'd2;

  // reg_sel codes: source of the register-file index
  localparam logic [REG_SEL_W-1:0] REG_SEL_RD   = 2'd0;
  localparam logic [REG_SEL_W-1:0] REG_SEL_RS   = 2'd1;
  localparam logic [REG_SEL_W-1:0] REG_SEL_RB   = 2'd2;
  localparam logic [REG_SEL_W-1:0] REG_SEL_CTRL = 2'd3;

  // Reserved microcode routines
  localparam logic [5:0] OP_RESET = 6'd0;
  localparam logic [5:0] OP_FETCH = 6'd1;

  // Opword field bit positions
  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RD_HI     = 25;
  localparam int RD_LO     = 21;
  localparam int RS_HI     = 20;
  localparam int RS_LO     = 16;
  localparam int RB_HI     = 15;
  localparam int RB_LO     = 11;

  // misc_plane value that restarts the micro-op counter
  localparam logic MISC_RESET_MICROOP_COUNTER = 1'b1;

endpackage
`default_nettype wire

// File: rtl/microop_sequencer_opword_field_mux.sv
`default_nettype none
// ============================================================================
// Module      : opword_field_mux
// Description : Resolves the ROM reg_sel field to a register-file index and
//               extracts the 16-bit immediate from the opword.
// Ports       : reg_sel   in  2   ROM reg_sel field
//               opword    in  32  current opword register
//               ctrl_data in  6   ROM ctrl_data field
//               reg_idx   out 5   resolved register-file index
//               immediate out 16  opword[15:0]
// Revision    : 1.0 - initial release
// ============================================================================
module opword_field_mux
  import microop_sequencer_pkg::*;
(
  input  logic [REG_SEL_W-1:0]   reg_sel,
  input  logic [31:0]            opword,
  input  logic [CTRL_DATA_W-1:0] ctrl_data,
  output logic [REG_IDX_W-1:0]   reg_idx,
  output logic [IMM_W-1:0]       immediate
);

  // Bits not consumed here: opcode field and ctrl_data[5]
  logic w_unused_bits;
  assign w_unused_bits = ^{opword[OPCODE_HI:OPCODE_LO], ctrl_data[CTRL_DATA_W-1]};

  assign immediate = opword[IMM_W-1:0];

  always_comb begin
    reg_idx = opword[RD_HI:RD_LO];
    case (reg_sel)
      REG_SEL_RD:   reg_idx = opword[RD_HI:RD_LO];
      REG_SEL_RS:   reg_idx = opword[RS_HI:RS_LO];
      REG_SEL_RB:   reg_idx = opword[RB_HI:RB_LO];
      REG_SEL_CTRL: reg_idx = ctrl_data[REG_IDX_W-1:0];
      default:      reg_idx = opword[RD_HI:RD_LO];
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/microop_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : microop_sequencer
// Description : Drives the microcode ROM address {opcode, microop_count} and
//               holds the opcode, micro-op counter and opword registers.
//               Consumes the ROM's decoded fields for the current step.
// Ports       : clk            in  1   system clock, rising edge
//               rst            in  1   synchronous active-high reset
//               n_booted       in  1   bootstrap in progress, hold in reset
//               stall          in  1   freeze all state this cycle
//               bus            in  32  system data bus
//               in_plane       in  3   ROM load selector
//               misc_plane     in  1   ROM: restart micro-op counter
//               opcode_sel     in  1   ROM: opcode from opword(0) / bus(1)
//               reg_sel        in  2   ROM register-index source
//               ctrl_data      in  6   ROM control data
//               microcode_addr out 11  ROM address, registered
//               opword         out 32  opword register
//               immediate      out 16  opword[15:0]
//               reg_idx        out 5   resolved register-file index
//               fault          out 1   sticky micro-op counter overflow
// Revision    : 1.0 - initial release
// ============================================================================
module microop_sequencer
  import microop_sequencer_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int COUNT_W  = 5,
  parameter int WORD_W   = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        n_booted,
  input  logic                        stall,
  input  logic [WORD_W-1:0]           bus,
  input  logic [IN_PLANE_W-1:0]       in_plane,
  input  logic                        misc_plane,
  input  logic                        opcode_sel,
  input  logic [REG_SEL_W-1:0]        reg_sel,
  input  logic [CTRL_DATA_W-1:0]      ctrl_data,
  output logic [OPCODE_W+COUNT_W-1:0] microcode_addr,
  output logic [WORD_W-1:0]           opword,
  output logic [IMM_W-1:0]            immediate,
  output logic [REG_IDX_W-1:0]        reg_idx,
  output logic                        fault
);

  localparam logic [COUNT_W-1:0] C_COUNT_MAX = '1;

  logic [OPCODE_W-1:0] r_opcode;
  logic [COUNT_W-1:0]  r_count;
  logic [WORD_W-1:0]   r_opword;
  logic                r_fault;

  logic w_hold_reset;
  logic w_overflow;

  // Bootstrap behaves exactly like reset and overrides stall
  assign w_hold_reset = rst | n_booted;
  // Stepping past the last micro-op without a counter restart is a fault
  assign w_overflow   = (r_count == C_COUNT_MAX) && (misc_plane != MISC_RESET_MICROOP_COUNTER);

  always_ff @(posedge clk) begin
    if (w_hold_reset) begin
      r_opcode <= OP_RESET;
      r_count  <= '0;
      r_opword <= '0;
      r_fault  <= 1'b0;
    end else if (!r_fault && !stall) begin
      if (w_overflow) begin
        // Freeze at the faulting address; only reset/bootstrap recovers
        r_fault <= 1'b1;
      end else begin
        r_count <= (misc_plane == MISC_RESET_MICROOP_COUNTER) ? '0 : r_count + 1'b1;
        case (in_plane)
          // Opword side uses the pre-edge register value
          IN_OPCODE: r_opcode <= opcode_sel ? bus[OPCODE_W-1:0]
                                            : r_opword[OPCODE_HI:OPCODE_LO];
          IN_OPWORD: r_opword <= bus;
          default: ;
        endcase
      end
    end
  end

  assign microcode_addr = {r_opcode, r_count};
  assign opword         = r_opword;
  assign fault          = r_fault;

  opword_field_mux u_field_mux (
    .reg_sel   (reg_sel),
    .opword    (r_opword),
    .ctrl_data (ctrl_data),
    .reg_idx   (reg_idx),
    .immediate (immediate)
  );

endmodule
`default_nettype wire
